// File: rtl/numeric_key_input_if.sv
// Keyboard byte stream into the numeric entry block, plus its committed value and display outputs.
// master = keyboard/sequencer side, slave = numeric_key_input.
interface numeric_key_input_if #(
   parameter int NDIGITS = 3,
   parameter int VALUE_W = 10
);
   logic [7:0]           data;
   logic                 data_en;
   logic [VALUE_W-1:0]   Value;
   logic                 value_valid;
   logic                 range_err;
   logic                 editing;
   logic [2:0]           count;
   logic [4*NDIGITS-1:0] digits;

   modport master (
      output data, data_en,
      input  Value, value_valid, range_err, editing, count, digits
   );

   modport slave (
      input  data, data_en,
      output Value, value_valid, range_err, editing, count, digits
   );
endinterface

// File: rtl/numeric_key_input.sv
// PS/2 numeric entry: up to NDIGITS BCD digits, Backspace/Enter/Escape, clamped commit with one-cycle strobe.
// Latency: commit visible one cycle after the Enter byte; no backpressure, every data_en byte is consumed.
module numeric_key_input #(
   parameter int NDIGITS  = 3,
   parameter int VALUE_W  = 10,
   parameter int MIN_VAL  = 0,
   parameter int MAX_VAL  = 999,
   parameter int INIT_VAL = 0
) (
   input  logic Clock,
   input  logic nReset,
   input  logic Enable,
   numeric_key_input_if.slave kb
);

   localparam int BW    = 4 * NDIGITS;
   localparam int RAW_W = VALUE_W + 4;

   localparam logic [7:0] KEY_ENTER = 8'h5A;
   localparam logic [7:0] KEY_BKSP  = 8'h66;
   localparam logic [7:0] KEY_ESC   = 8'h76;
   localparam logic [7:0] KEY_BREAK = 8'hF0;
   localparam logic [7:0] KEY_EXT   = 8'hE0;

   typedef enum logic {IDLE = 1'b0, EDIT = 1'b1} state_t;

   state_t               state_q, state_d;
   logic                 brk_q, ext_q;
   logic [BW-1:0]        buf_q, buf_d;
   logic [2:0]           count_q, count_d;
   logic [VALUE_W-1:0]   value_q, value_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;

   logic                 is_prefix;
   logic                 accepted;
   logic                 key_is_digit;
   logic [3:0]           key_digit;
   logic [RAW_W-1:0]     raw;
   logic                 above_max, below_min;
   logic [VALUE_W-1:0]   clamp_val;
   logic [BW-1:0]        value_bcd;
   logic [VALUE_W-1:0]   rem_val;

   // Prefix flags follow the byte stream even while another block owns the keyboard.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         brk_q <= 1'b0;
         ext_q <= 1'b0;
      end else if (kb.data_en) begin
         if (kb.data == KEY_BREAK) begin
            brk_q <= 1'b1;
         end else if (kb.data == KEY_EXT) begin
            ext_q <= 1'b1;
         end else begin
            brk_q <= 1'b0;
            ext_q <= 1'b0;
         end
      end
   end

   assign is_prefix = (kb.data == KEY_BREAK) || (kb.data == KEY_EXT);
   assign accepted  = kb.data_en && !is_prefix && !brk_q && !ext_q && Enable;

   always_comb begin
      key_is_digit = 1'b1;
      key_digit    = 4'd0;
      case (kb.data)
         8'h45:   key_digit = 4'd0;
         8'h16:   key_digit = 4'd1;
         8'h1E:   key_digit = 4'd2;
         8'h26:   key_digit = 4'd3;
         8'h25:   key_digit = 4'd4;
         8'h2E:   key_digit = 4'd5;
         8'h36:   key_digit = 4'd6;
         8'h3D:   key_digit = 4'd7;
         8'h3E:   key_digit = 4'd8;
         8'h46:   key_digit = 4'd9;
         default: key_is_digit = 1'b0;
      endcase
   end

   // Widened by four bits so an unclamped buffer can never wrap before the range test.
   always_comb begin
      raw = '0;
      for (int i = NDIGITS - 1; i >= 0; i--) begin
         raw = raw * RAW_W'(10) + RAW_W'(buf_q[4*i +: 4]);
      end
   end

   assign above_max = raw > RAW_W'(MAX_VAL);

   generate
      if (MIN_VAL > 0) begin : g_min
         assign below_min = raw < RAW_W'(MIN_VAL);
      end else begin : g_nomin
         assign below_min = 1'b0;
      end
   endgenerate

   always_comb begin
      clamp_val = VALUE_W'(raw);
      if (above_max) begin
         clamp_val = VALUE_W'(MAX_VAL);
      end else if (below_min) begin
         clamp_val = VALUE_W'(MIN_VAL);
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         buf_q   <= '0;
         count_q <= '0;
         value_q <= VALUE_W'(INIT_VAL);
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         count_q <= count_d;
         value_q <= value_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      count_d = count_q;
      value_d = value_q;
      valid_d = 1'b0;
      err_d   = 1'b0;

      if (!Enable) begin
         state_d = IDLE;
         buf_d   = '0;
         count_d = '0;
      end else if (accepted) begin
         case (state_q)
            IDLE: begin
               if (key_is_digit) begin
                  buf_d   = BW'(key_digit);
                  count_d = 3'd1;
                  state_d = EDIT;
               end
            end
            EDIT: begin
               if (key_is_digit) begin
                  if (count_q < 3'(NDIGITS)) begin
                     buf_d   = (buf_q << 4) | BW'(key_digit);
                     count_d = count_q + 3'd1;
                  end
               end else begin
                  case (kb.data)
                     KEY_BKSP: begin
                        if (count_q != 3'd0) begin
                           buf_d   = buf_q >> 4;
                           count_d = count_q - 3'd1;
                        end
                     end
                     KEY_ESC: begin
                        state_d = IDLE;
                        buf_d   = '0;
                        count_d = '0;
                     end
                     KEY_ENTER: begin
                        state_d = IDLE;
                        buf_d   = '0;
                        count_d = '0;
                        if (count_q != 3'd0) begin
                           value_d = clamp_val;
                           valid_d = 1'b1;
                           err_d   = above_max || below_min;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      value_bcd = '0;
      rem_val   = value_q;
      for (int i = 0; i < NDIGITS; i++) begin
         value_bcd[4*i +: 4] = 4'(rem_val % VALUE_W'(10));
         rem_val             = rem_val / VALUE_W'(10);
      end
   end

   assign kb.Value       = value_q;
   assign kb.value_valid = valid_q;
   assign kb.range_err   = err_q;
   assign kb.editing     = (state_q == EDIT);
   assign kb.count       = count_q;
   assign kb.digits      = (state_q == EDIT) ? buf_q : value_bcd;

endmodule

// File: tb/tb_numeric_key_input.sv
// Bench for numeric_key_input: two instances (default range and a narrow 5..240 range) share one byte stream.
module tb_numeric_key_input;

   logic Clock = 1'b0;
   logic nReset;
   logic Enable;

   always #5 Clock = ~Clock;

   numeric_key_input_if #(.NDIGITS(3), .VALUE_W(10)) k0 ();
   numeric_key_input_if #(.NDIGITS(3), .VALUE_W(10)) k1 ();

   numeric_key_input #(.NDIGITS(3), .VALUE_W(10), .MIN_VAL(0), .MAX_VAL(999), .INIT_VAL(0)) dut0 (
      .Clock(Clock), .nReset(nReset), .Enable(Enable), .kb(k0)
   );

   numeric_key_input #(.NDIGITS(3), .VALUE_W(10), .MIN_VAL(5), .MAX_VAL(240), .INIT_VAL(5)) dut1 (
      .Clock(Clock), .nReset(nReset), .Enable(Enable), .kb(k1)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] dcode [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   int lo_b   [2] = '{0, 5};
   int hi_b   [2] = '{999, 240};
   int init_b [2] = '{0, 5};

   // Reference model: entered digits kept most-significant first.
   int ent [$];
   bit m_edit, m_brk, m_ext, m_vld;
   bit m_err [2];
   int m_val [2];

   function automatic int digit_of(logic [7:0] b);
      for (int i = 0; i < 10; i++) if (dcode[i] == b) return i;
      return -1;
   endfunction

   function automatic int ent_num();
      int n = 0;
      foreach (ent[i]) n = n * 10 + ent[i];
      return n;
   endfunction

   function automatic logic [11:0] bcd3(int n);
      logic [11:0] r;
      r[3:0]  = 4'(n % 10);
      r[7:4]  = 4'((n / 10) % 10);
      r[11:8] = 4'((n / 100) % 10);
      return r;
   endfunction

   task automatic model_reset();
      ent.delete();
      m_edit = 0; m_brk = 0; m_ext = 0; m_vld = 0;
      for (int k = 0; k < 2; k++) begin
         m_err[k] = 0;
         m_val[k] = init_b[k];
      end
   endtask

   task automatic model_cycle(bit en, bit de, logic [7:0] b);
      bit acc;
      int d;
      int raw;
      acc = 0;
      m_vld = 0;
      m_err[0] = 0;
      m_err[1] = 0;
      if (de) begin
         if (b == 8'hF0) m_brk = 1;
         else if (b == 8'hE0) m_ext = 1;
         else begin
            acc = !m_brk && !m_ext;
            m_brk = 0;
            m_ext = 0;
         end
      end
      if (!en) begin
         m_edit = 0;
         ent.delete();
         return;
      end
      if (!acc) return;
      d = digit_of(b);
      if (!m_edit) begin
         if (d >= 0) begin
            ent.delete();
            ent.push_back(d);
            m_edit = 1;
         end
      end else if (d >= 0) begin
         if (ent.size() < 3) ent.push_back(d);
      end else if (b == 8'h66) begin
         if (ent.size() > 0) void'(ent.pop_back());
      end else if (b == 8'h76) begin
         m_edit = 0;
         ent.delete();
      end else if (b == 8'h5A) begin
         if (ent.size() > 0) begin
            raw = ent_num();
            for (int k = 0; k < 2; k++) begin
               m_err[k] = (raw > hi_b[k]) || (raw < lo_b[k]);
               m_val[k] = (raw > hi_b[k]) ? hi_b[k] : (raw < lo_b[k]) ? lo_b[k] : raw;
            end
            m_vld = 1;
         end
         m_edit = 0;
         ent.delete();
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("value0",  32'(k0.Value),       32'(m_val[0]));
      chk("vld0",    32'(k0.value_valid), 32'(m_vld));
      chk("err0",    32'(k0.range_err),   32'(m_err[0]));
      chk("edit0",   32'(k0.editing),     32'(m_edit));
      chk("count0",  32'(k0.count),       32'(ent.size()));
      chk("digits0", 32'(k0.digits),      32'(m_edit ? bcd3(ent_num()) : bcd3(m_val[0])));
      chk("value1",  32'(k1.Value),       32'(m_val[1]));
      chk("vld1",    32'(k1.value_valid), 32'(m_vld));
      chk("err1",    32'(k1.range_err),   32'(m_err[1]));
      chk("edit1",   32'(k1.editing),     32'(m_edit));
      chk("count1",  32'(k1.count),       32'(ent.size()));
      chk("digits1", 32'(k1.digits),      32'(m_edit ? bcd3(ent_num()) : bcd3(m_val[1])));
   endtask

   // Called at a falling edge: drive one cycle, then check after the rising edge.
   task automatic step(bit en, bit de, logic [7:0] b);
      Enable     = en;
      k0.data    = b;
      k0.data_en = de;
      k1.data    = b;
      k1.data_en = de;
      model_cycle(en, de, b);
      @(negedge Clock);
      check_all();
   endtask

   task automatic send(logic [7:0] b);
      step(1'b1, 1'b1, b);
      step(1'b1, 1'b0, 8'h00);
   endtask

   logic [7:0] seq2 [9] = '{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h5A, 8'hF0, 8'h5A};
   logic [7:0] special [5] = '{8'h5A, 8'h66, 8'h76, 8'hF0, 8'hE0};

   initial begin
      nReset = 1'b0;
      Enable = 1'b0;
      k0.data = 8'h00; k0.data_en = 1'b0;
      k1.data = 8'h00; k1.data_en = 1'b0;
      model_reset();
      repeat (2) @(negedge Clock);
      check_all();
      chk("rst_digits", 32'(k0.digits), 32'h000);
      nReset = 1'b1;
      step(1'b1, 1'b0, 8'h00);

      // Break codes are dropped; only the make codes enter 1,2 then commit.
      foreach (seq2[i]) send(seq2[i]);
      chk("tp2_value", 32'(k0.Value), 32'd12);
      chk("tp2_count", 32'(k0.count), 32'd0);

      // 300 clamps to 240 on the narrow instance.
      send(8'h26); send(8'h45); send(8'h45);
      step(1'b1, 1'b1, 8'h5A);
      chk("clamp_hi_val", 32'(k1.Value), 32'd240);
      chk("clamp_hi_err", 32'(k1.range_err), 32'd1);
      chk("noclamp_val", 32'(k0.Value), 32'd300);
      step(1'b1, 1'b0, 8'h00);

      // 2 clamps up to 5.
      send(8'h1E);
      step(1'b1, 1'b1, 8'h5A);
      chk("clamp_lo_val", 32'(k1.Value), 32'd5);
      chk("clamp_lo_err", 32'(k1.range_err), 32'd1);
      step(1'b1, 1'b0, 8'h00);

      // Fourth digit ignored, backspace, commit.
      send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
      chk("full_digits", 32'(k0.digits), 32'h123);
      chk("full_count", 32'(k0.count), 32'd3);
      send(8'h66);
      chk("bksp_digits", 32'(k0.digits), 32'h012);
      send(8'h5A);
      chk("bksp_value", 32'(k0.Value), 32'd12);

      // Escape discards the entry.
      send(8'h46); send(8'h46); send(8'h76);
      chk("esc_value", 32'(k0.Value), 32'd12);
      chk("esc_digits", 32'(k0.digits), 32'h012);

      // Enable dropped mid-entry.
      send(8'h25); send(8'h2E);
      step(1'b0, 1'b0, 8'h00);
      chk("en_low_edit", 32'(k0.editing), 32'd0);
      step(1'b1, 1'b0, 8'h00);

      // Extended Enter must not commit.
      send(8'h3D); send(8'hE0); send(8'h5A);
      chk("ext_enter_edit", 32'(k0.editing), 32'd1);

      // Asynchronous reset in the middle of an entry.
      #2 nReset = 1'b0;
      #1 model_reset();
      check_all();
      chk("rst_mid_value1", 32'(k1.Value), 32'd5);
      @(negedge Clock);
      nReset = 1'b1;
      step(1'b1, 1'b0, 8'h00);

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         int r;
         logic [7:0] b;
         r = int'($urandom_range(0, 15));
         if (r < 10)      b = dcode[r];
         else if (r < 15) b = special[r - 10];
         else             b = 8'($urandom_range(0, 255));
         step($urandom_range(0, 24) != 0, $urandom_range(0, 2) != 0, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/numeric_key_input.md
Name: numeric_key_input

Overview:
Parametrised PS/2 scan-code numeric entry block, successor to the two-digit loop-count entry controller. It accepts up to NDIGITS decimal digits from the keyboard byte stream and supports Backspace, Enter and Escape. On commit it clamps the value to [MIN_VAL, MAX_VAL] and issues a one-cycle valid strobe. It drives live BCD digits for the 7-segment display drivers and serves the BPM, loop-count and step-count inputs of the sequencer.

Parameters:
NDIGITS, 3, maximum number of decimal digits accepted (1..4)
VALUE_W, 10, width of the committed binary value; must hold 10^NDIGITS-1
MIN_VAL, 0, lower clamp bound for commit
MAX_VAL, 999, upper clamp bound for commit; MIN_VAL <= MAX_VAL < 10^NDIGITS
INIT_VAL, 0, committed value after reset; must lie within [MIN_VAL, MAX_VAL]

Ports:
Clock  input  1  system clock
nReset  input  1  asynchronous active-low reset
Enable  input  1  block owns the keyboard when high
data  input  8  PS/2 scan-code byte
data_en  input  1  one-cycle strobe marking data as valid
Value  output  VALUE_W  committed, clamped value
value_valid  output  1  one-cycle pulse on each commit
range_err  output  1  one-cycle pulse, coincident with value_valid, when the commit was clamped
editing  output  1  high while in EDIT
count  output  3  number of digits currently entered (0..NDIGITS)
digits  output  4*NDIGITS  BCD display digits; digit 0 (ones) is in bits [3:0]

Behaviour:
- Reset and clock: reset nReset, asynchronous, active-low; clock Clock. All state updates on the rising edge of Clock.
- Reset values: Value=INIT_VAL, value_valid=0, range_err=0, editing=0, count=0, break flag=0, extended flag=0, state=IDLE, BCD buffer=0.
- Scan codes: digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to 0-9. Enter=0x5A, Backspace=0x66, Escape=0x76, release prefix=0xF0, extended prefix=0xE0.
- Prefix filtering, applied only on cycles where data_en is high:
  - 0xF0 sets the break flag.
  - 0xE0 sets the extended flag.
  - Any other byte is "accepted" only if both flags are 0. Otherwise it is dropped.
  - Both flags clear on any non-prefix byte.
  - Extended Enter (E0 5A) is therefore ignored.
- The accepted-key path runs only when Enable=1. The prefix flags track the stream regardless of Enable.
- State IDLE:
  - Accepted digit: buffer = {0,...,0,d}, count=1, go to EDIT.
  - All other keys are ignored.
- State EDIT:
  - Digit with count<NDIGITS: buffer shifts up one BCD place, d enters the ones place, count+1.
  - Digit with count==NDIGITS: ignored (buffer full, no error).
  - Backspace: buffer shifts down one place, top digit becomes 0, count-1. If count reaches 0, stay in EDIT.
  - Escape: discard the buffer, count=0, go to IDLE. Value is unchanged and no strobe is issued.
  - Enter with count==0: go to IDLE with no commit.
  - Enter with count>0:
    - raw = sum of buffer digits times powers of ten.
    - Value = MAX_VAL if raw>MAX_VAL; MIN_VAL if raw<MIN_VAL; otherwise raw.
    - range_err=1 if clamped.
    - value_valid=1 for exactly the cycle after the Enter byte's data_en cycle. Value is updated on the same edge.
    - Go to IDLE, count=0.
- Enable low: state forced to IDLE on the next edge, buffer cleared, count=0. Value is held and no strobe is issued.
- editing = (state==EDIT).
- Display: in EDIT, digits = buffer, with leading zeros shown. In IDLE, digits = BCD of Value, via combinational div/mod by 10 per place.
- Width rule: the raw sum is computed at VALUE_W+4 bits before clamping, so there is no overflow for any buffer content.
- Reset asserted mid-entry immediately returns all registers to their reset values.

Test Plan:
- Reset with defaults -> Value=0, digits=000, editing=0, count=0.
- Bytes 16,F0,16, 1E,F0,1E, 5A,F0,5A -> Value=12, value_valid pulses once, range_err=0, count=0 afterward.
- MAX_VAL=240: enter 3,0,0,Enter -> Value=240, range_err=1; MIN_VAL=5: enter 2,Enter -> Value=5, range_err=1.
- Enter 1,2,3,4 with NDIGITS=3 -> buffer 123, count=3; then Backspace -> 012, count=2; then Enter -> Value=12.
- Value=12, then enter 9,9 and Escape -> Value stays 12, no value_valid, digits show 012.
- Drop Enable mid-entry (count=2) -> IDLE, count=0, no strobe; E0 5A while in EDIT -> no commit; nReset pulse during EDIT -> Value=INIT_VAL.
